// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO with sticky overrun/framing flags.
// Outputs are registered; q holds the head byte, precomputed from the next read pointer.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              rdreq,
    input  logic              clear_err,
    output logic [7:0]        q,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic              frame_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_P    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic                r_rxMeta;
    logic                r_rxs;
    state_t              r_state;
    logic [CNT_W-1:0]    r_sampCnt;
    logic [2:0]          r_bitCnt;
    logic [7:0]          r_shift;

    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wrPtr;
    logic [ADDR_W-1:0]   r_rdPtr;
    logic [ADDR_W:0]     r_count;
    logic                r_empty;
    logic                r_full;
    logic [7:0]          r_q;
    logic                r_overrun;
    logic                r_frameErr;

    logic                w_sampleNow;
    logic                w_push;
    logic                w_stopLow;
    logic                w_pop;
    logic                w_wr;
    logic                w_drop;
    logic [ADDR_W-1:0]   w_rdPtrNext;
    logic [ADDR_W:0]     w_countNext;
    logic [7:0]          w_qNext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxMeta <= 1'b1;
            r_rxs    <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxs    <= r_rxMeta;
        end
    end

    assign w_sampleNow = (r_sampCnt == '0);
    assign w_push      = (r_state == S_STOP) && w_sampleNow && r_rxs;
    assign w_stopLow   = (r_state == S_STOP) && w_sampleNow && !r_rxs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sampCnt <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        r_sampCnt <= HALF_M1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_sampleNow) begin
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_DATA;
                            r_sampCnt <= BIT_M1;
                            r_bitCnt  <= '0;
                        end
                    end else begin
                        r_sampCnt <= r_sampCnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_sampleNow) begin
                        r_shift   <= {r_rxs, r_shift[7:1]};
                        r_sampCnt <= BIT_M1;
                        if (r_bitCnt == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end else begin
                        r_sampCnt <= r_sampCnt - CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (w_sampleNow) begin
                        r_state <= r_rxs ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        r_sampCnt <= r_sampCnt - CNT_ONE;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop is kept.
    assign w_pop       = rdreq && !r_empty;
    assign w_wr        = w_push && (!r_full || w_pop);
    assign w_drop      = w_push && r_full && !w_pop;
    assign w_rdPtrNext = w_pop ? (r_rdPtr + ONE_P) : r_rdPtr;
    assign w_qNext     = (w_wr && (r_wrPtr == w_rdPtrNext)) ? r_shift : r_mem[w_rdPtrNext];

    always_comb begin
        w_countNext = r_count;
        if (w_wr && !w_pop) begin
            w_countNext = r_count + ONE_C;
        end else if (!w_wr && w_pop) begin
            w_countNext = r_count - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            r_mem[r_wrPtr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_q        <= 8'h00;
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + ONE_P;
            end
            r_rdPtr <= w_rdPtrNext;
            r_count <= w_countNext;
            r_empty <= (w_countNext == '0);
            r_full  <= (w_countNext == CNT_FULL);
            r_q     <= w_qNext;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end
            if (w_stopLow) begin
                r_frameErr <= 1'b1;
            end else if (clear_err) begin
                r_frameErr <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign empty     = r_empty;
    assign full      = r_full;
    assign count     = r_count;
    assign overrun   = r_overrun;
    assign frame_err = r_frameErr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 8 clocks per bit: a vector table of single
// frames plus hand-written sequences for false starts, breaks, overflow and reset.
module tb_uart_rx_fifo;

    localparam int CPB = 8;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          rdreq;
    logic          clear_err;
    logic [7:0]    q;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] txByte;
        logic [7:0] expQ;
        int         expCount;
    } vec_t;

    vec_t vecs [6];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rdreq     (rdreq),
        .clear_err (clear_err),
        .q         (q),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                             input bit rdAtStop, input int rstBit);
        logic [9:0] frame;
        frame = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            for (int c = 0; c < CPB; c++) begin
                if (rdAtStop && i == 9 && c == 6) rdreq = 1'b1;
                if (rstBit >= 0 && i == rstBit + 1 && c == 4) rst_n = 1'b0;
                @(posedge clk);
                #1;
                rdreq = 1'b0;
                rst_n = 1'b1;
            end
        end
    endtask

    task automatic checkState(input string tag, input int expEmpty, input int expFull,
                              input int expCount, input int expOvr, input int expFe);
        @(negedge clk);
        checkOutput({tag, "_empty"}, int'(empty), expEmpty);
        checkOutput({tag, "_full"}, int'(full), expFull);
        checkOutput({tag, "_count"}, int'(count), expCount);
        checkOutput({tag, "_overrun"}, int'(overrun), expOvr);
        checkOutput({tag, "_frame_err"}, int'(frame_err), expFe);
        @(posedge clk);
        #1;
    endtask

    task automatic popCheck(input string tag, input logic [7:0] expQ);
        @(negedge clk);
        checkOutput({tag, "_nonempty"}, int'(empty), 0);
        checkOutput({tag, "_q"}, int'(q), int'(expQ));
        rdreq = 1'b1;
        @(posedge clk);
        #1;
        rdreq = 1'b0;
    endtask

    task automatic pulseClear();
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        sendFrame(v.txByte, 1'b1, 1'b0, -1);
        idle(4);
        checkState(tag, 0, 0, v.expCount, 0, 0);
        popCheck(tag, v.expQ);
        checkState({tag, "_popped"}, 1, 0, 0, 0, 0);
    endtask

    initial begin
        vecs[0] = '{txByte: 8'hA5, expQ: 8'hA5, expCount: 1};
        vecs[1] = '{txByte: 8'h3C, expQ: 8'h3C, expCount: 1};
        vecs[2] = '{txByte: 8'h00, expQ: 8'h00, expCount: 1};
        vecs[3] = '{txByte: 8'hFF, expQ: 8'hFF, expCount: 1};
        vecs[4] = '{txByte: 8'h80, expQ: 8'h80, expCount: 1};
        vecs[5] = '{txByte: 8'h01, expQ: 8'h01, expCount: 1};

        rst_n     = 1'b0;
        rx        = 1'b1;
        rdreq     = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_empty", int'(empty), 1);
        checkOutput("reset_full", int'(full), 0);
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        checkOutput("reset_frame_err", int'(frame_err), 0);
        checkOutput("reset_q", int'(q), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Short low glitch must be rejected at the mid-start sample.
        rx = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(20);
        checkState("false_start", 1, 0, 0, 0, 0);
        sendFrame(8'h3C, 1'b1, 1'b0, -1);
        idle(4);
        checkState("after_glitch", 0, 0, 1, 0, 0);
        popCheck("after_glitch", 8'h3C);

        rdreq = 1'b1;
        idle(3);
        rdreq = 1'b0;
        checkState("underflow", 1, 0, 0, 0, 0);
        sendFrame(8'h5A, 1'b1, 1'b0, -1);
        idle(4);
        checkState("post_underflow", 0, 0, 1, 0, 0);
        popCheck("post_underflow", 8'h5A);

        // Bad stop bit followed by a long break.
        sendFrame(8'h55, 1'b0, 1'b0, -1);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        checkState("break", 1, 0, 0, 0, 1);
        idle(10);
        sendFrame(8'h01, 1'b1, 1'b0, -1);
        idle(4);
        checkState("after_break", 0, 0, 1, 0, 1);
        popCheck("after_break", 8'h01);
        pulseClear();
        checkState("fe_cleared", 1, 0, 0, 0, 0);

        for (int i = 0; i <= 16; i++) begin
            sendFrame(8'(i), 1'b1, 1'b0, -1);
            idle(2);
        end
        checkState("overflow", 0, 1, 16, 1, 0);
        for (int i = 0; i < 16; i++) begin
            popCheck($sformatf("drain%0d", i), 8'(i));
        end
        checkState("drained", 1, 0, 0, 1, 0);
        pulseClear();
        checkState("ovr_cleared", 1, 0, 0, 0, 0);

        // Refill, then pop on the very cycle the 0xAA stop bit is sampled.
        for (int i = 0; i < 16; i++) begin
            sendFrame(8'(i), 1'b1, 1'b0, -1);
            idle(2);
        end
        checkState("refill", 0, 1, 16, 0, 0);
        sendFrame(8'hAA, 1'b1, 1'b1, -1);
        idle(4);
        checkState("full_push_pop", 0, 1, 16, 0, 0);
        for (int i = 0; i < 15; i++) begin
            popCheck($sformatf("wrap%0d", i), 8'(i + 1));
        end
        popCheck("wrap_last", 8'hAA);
        checkState("wrap_empty", 1, 0, 0, 0, 0);

        // Reset in the middle of a frame with data queued and frame_err set.
        sendFrame(8'h0F, 1'b0, 1'b0, -1);
        idle(4);
        sendFrame(8'h11, 1'b1, 1'b0, -1);
        sendFrame(8'h22, 1'b1, 1'b0, -1);
        sendFrame(8'h33, 1'b1, 1'b0, -1);
        idle(4);
        checkState("pre_reset", 0, 0, 3, 0, 1);
        sendFrame(8'hF0, 1'b1, 1'b0, 5);
        idle(8);
        checkState("mid_reset", 1, 0, 0, 0, 0);
        sendFrame(8'h7E, 1'b1, 1'b0, -1);
        idle(4);
        checkState("post_reset", 0, 0, 1, 0, 0);
        popCheck("post_reset", 8'h7E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
